// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: one down-counter per architectural register
// tracking cycles until its pending result becomes forwardable.
module hazard_scoreboard #(
    parameter int MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rgS1_index_ID,
    input  logic [4:0]  rgS2_index_ID,
    input  logic        useS1_ID,
    input  logic        useS2_ID,
    input  logic [4:0]  rgD_index_ID,
    input  logic        writeRg_ID,
    input  logic [1:0]  lat_class_ID,
    input  logic        issue_valid,
    input  logic        freeze,
    input  logic        done_valid,
    input  logic [4:0]  done_index,
    output logic        stall_ID,
    output logic [31:0] pending_mask
);

    localparam logic [2:0] CNT_VAR = 3'd7;

    logic [2:0] r_cnt [32];
    logic [2:0] w_load_val;
    logic       w_issue_ld;
    logic       w_raw_s1;
    logic       w_raw_s2;
    logic       w_waw;

    always_comb begin
        w_load_val = 3'd0;
        case (lat_class_ID)
            2'd0:    w_load_val = 3'd0;
            2'd1:    w_load_val = 3'd1;
            2'd2:    w_load_val = 3'(MUL_LAT);
            default: w_load_val = CNT_VAR;
        endcase
    end

    // r_cnt[0] is held at zero, so the index!=0 terms are belt-and-braces
    assign w_raw_s1 = useS1_ID & (rgS1_index_ID != 5'd0) & (r_cnt[rgS1_index_ID] != 3'd0);
    assign w_raw_s2 = useS2_ID & (rgS2_index_ID != 5'd0) & (r_cnt[rgS2_index_ID] != 3'd0);
    assign w_waw    = writeRg_ID & (rgD_index_ID != 5'd0) & (r_cnt[rgD_index_ID] == CNT_VAR);
    assign stall_ID = w_raw_s1 | w_raw_s2 | w_waw;

    assign w_issue_ld = issue_valid & ~stall_ID & ~freeze & writeRg_ID & (rgD_index_ID != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= 3'd0;
            end
        end else begin
            r_cnt[0] <= 3'd0;
            for (int i = 1; i < 32; i++) begin
                // issue beats done-clear beats decrement for the same register
                if (w_issue_ld && (rgD_index_ID == 5'(i))) begin
                    r_cnt[i] <= w_load_val;
                end else if (done_valid && (done_index == 5'(i)) && (r_cnt[i] == CNT_VAR)) begin
                    r_cnt[i] <= 3'd0;
                end else if (!freeze && (r_cnt[i] != 3'd0) && (r_cnt[i] != CNT_VAR)) begin
                    r_cnt[i] <= r_cnt[i] - 3'd1;
                end
            end
        end
    end

    always_comb begin
        pending_mask = 32'd0;
        for (int i = 1; i < 32; i++) begin
            pending_mask[i] = (r_cnt[i] != 3'd0);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: driver pushes predicted stall/mask per cycle, a negedge
// monitor pops and compares; reference tracks remaining cycles per register.
module tb_hazard_scoreboard;

    localparam int MUL_LAT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rgS1_index_ID, rgS2_index_ID, rgD_index_ID, done_index;
    logic        useS1_ID, useS2_ID, writeRg_ID, issue_valid, freeze, done_valid;
    logic [1:0]  lat_class_ID;
    logic        stall_ID;
    logic [31:0] pending_mask;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset),
        .rgS1_index_ID(rgS1_index_ID), .rgS2_index_ID(rgS2_index_ID),
        .useS1_ID(useS1_ID), .useS2_ID(useS2_ID),
        .rgD_index_ID(rgD_index_ID), .writeRg_ID(writeRg_ID),
        .lat_class_ID(lat_class_ID), .issue_valid(issue_valid),
        .freeze(freeze), .done_valid(done_valid), .done_index(done_index),
        .stall_ID(stall_ID), .pending_mask(pending_mask)
    );

    typedef struct packed {
        logic        stall;
        logic [31:0] mask;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rem[32];     // cycles (unfrozen) until forwardable
    bit          vpend[32];   // waiting on an external done
    logic        last_stall;
    logic [31:0] last_mask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit pend(int r);
        return (r != 0) && (vpend[r] || rem[r] > 0);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.stall = (useS1_ID && pend(int'(rgS1_index_ID))) ||
                  (useS2_ID && pend(int'(rgS2_index_ID))) ||
                  (writeRg_ID && rgD_index_ID != 0 && vpend[rgD_index_ID]);
        e.mask = 32'd0;
        for (int r = 1; r < 32; r++) e.mask[r] = pend(r);
        return e;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            rem[r] = 0;
            vpend[r] = 0;
        end
    endfunction

    function automatic void model_edge(bit stall);
        bit issue;
        int rd;
        rd    = int'(rgD_index_ID);
        issue = issue_valid && !stall && !freeze && writeRg_ID && rd != 0;
        for (int r = 1; r < 32; r++) begin
            if (issue && r == rd) begin
                vpend[r] = (lat_class_ID == 2'd3);
                case (lat_class_ID)
                    2'd0:    rem[r] = 0;
                    2'd1:    rem[r] = 1;
                    2'd2:    rem[r] = MUL_LAT;
                    default: rem[r] = 0;
                endcase
            end else if (done_valid && int'(done_index) == r && vpend[r]) begin
                vpend[r] = 0;
            end else if (!freeze && rem[r] > 0) begin
                rem[r] = rem[r] - 1;
            end
        end
    endfunction

    // one cycle: drive at posedge+1, monitor compares at negedge, model advances at posedge
    task automatic step(input int s1, input int u1, input int s2, input int u2,
                        input int rd, input int wr, input int cls, input int iv,
                        input int frz, input int dv, input int di);
        exp_t e;
        rgS1_index_ID = 5'(s1);  useS1_ID   = 1'(u1);
        rgS2_index_ID = 5'(s2);  useS2_ID   = 1'(u2);
        rgD_index_ID  = 5'(rd);  writeRg_ID = 1'(wr);
        lat_class_ID  = 2'(cls); issue_valid = 1'(iv);
        freeze        = 1'(frz); done_valid  = 1'(dv);
        done_index    = 5'(di);
        e = predict();
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        last_stall = stall_ID;
        last_mask  = pending_mask;
        @(posedge clk);
        if (reset) model_edge(e.stall);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_stall", {31'd0, stall_ID}, {31'd0, e.stall});
                chk("sb_mask", pending_mask, e.mask);
            end
        end
    end

    initial begin : driver
        int n;
        bit all7;
        model_clear();
        reset = 1'b0;
        step(5, 1, 6, 1, 5, 1, 3, 1, 0, 0, 0);
        step(5, 1, 6, 1, 6, 1, 2, 1, 0, 0, 0);
        chk("reset_mask", last_mask, 32'd0);
        chk("reset_stall", {31'd0, last_stall}, 32'd0);
        reset = 1'b1;

        // load-use
        step(0, 0, 0, 0, 5, 1, 1, 1, 0, 0, 0);
        step(5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("loaduse_stall", {31'd0, last_stall}, 32'd1);
        chk("loaduse_mask", last_mask, 32'h20);
        step(5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("loaduse_release", {31'd0, last_stall}, 32'd0);
        chk("loaduse_mask_clr", last_mask, 32'd0);

        // multiply, then multiply with two frozen cycles
        for (int pass = 0; pass < 2; pass++) begin
            step(0, 0, 0, 0, 3, 1, 2, 1, 0, 0, 0);
            n = 0;
            for (int k = 0; k < 20; k++) begin
                step(3, 1, 0, 0, 0, 0, 0, 1, (pass == 1 && (k == 1 || k == 2)) ? 1 : 0, 0, 0);
                if (!last_stall) break;
                n++;
            end
            chk(pass == 0 ? "mul_stall_cycles" : "mul_freeze_stall_cycles", 32'(n),
                pass == 0 ? 32'd5 : 32'd7);
        end

        // variable latency with WAW from ID
        step(0, 0, 0, 0, 7, 1, 3, 1, 0, 0, 0);
        n = 0;
        all7 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(7, 1, 0, 0, 7, 1, 3, 1, 0, 0, 0);
            if (last_stall) n++;
            all7 = all7 & last_mask[7];
        end
        chk("var_stall_cycles", 32'(n), 32'd20);
        chk("var_pending_held", {31'd0, all7}, 32'd1);
        step(7, 1, 0, 0, 7, 1, 3, 1, 0, 1, 7);
        chk("var_done_cycle_stall", {31'd0, last_stall}, 32'd1);
        step(7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("var_released", {31'd0, last_stall}, 32'd0);
        chk("var_mask_clr", {31'd0, last_mask[7]}, 32'd0);

        // same-edge issue to r9 (WAW-stalled from ID) and done r9
        step(0, 0, 0, 0, 9, 1, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 9, 1, 2, 1, 0, 1, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // register 0 and ALU results never pend
        step(0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0);
        step(0, 1, 4, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("r0_alu_stall", {31'd0, last_stall}, 32'd0);
        chk("r0_alu_mask", last_mask, 32'd0);

        // asynchronous reset mid-operation
        step(0, 0, 0, 0, 2, 1, 2, 1, 0, 0, 0);
        step(0, 0, 0, 0, 6, 1, 3, 1, 0, 0, 0);
        rgS1_index_ID = 5'd2; useS1_ID = 1'b1;
        rgS2_index_ID = 5'd6; useS2_ID = 1'b1;
        rgD_index_ID  = 5'd6; writeRg_ID = 1'b1; issue_valid = 1'b0;
        #1;
        chk("pre_reset_mask", pending_mask, 32'h44);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        chk("async_reset_mask", pending_mask, 32'd0);
        chk("async_reset_stall", {31'd0, stall_ID}, 32'd0);
        step(2, 1, 6, 1, 6, 1, 3, 0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        step(6, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("post_reset_done_mask", last_mask, 32'd0);

        // randomized traffic on a narrow register window to force hazards
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 3), ($urandom_range(0, 3) != 0) ? 1 : 0,
                 ($urandom_range(0, 4) == 0) ? 1 : 0,
                 ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 7));
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
